en_gen_multi: RTL

//  Multi-channel enable/blink generator; parametrised successor of the single 1 Hz en_gen.
//  A shared prescaler derives a base tick from clk; NUM_CH channel dividers each emit a
//  1-clk enable pulse and a blink mask at a runtime-programmable period.

---
 rtl/en_gen_pkg.sv | 18 +
 rtl/en_gen_ch.sv | 75 +++++++
 rtl/en_gen_multi.sv | 63 ++++++
 3 files changed

// File: rtl/en_gen_pkg.sv
// Shared helpers for the multi-channel enable generator.
// EN_GEN_DUTY_EN (when defined) adds a per-channel duty input; this package is the same either way.
package en_gen_pkg;

  localparam int DIV_W_DEF = 16;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Prescaler terminal count; the caller guarantees an exact division with a result of at least 2.
  function automatic int pre_val(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int pre_width(input int pre);
    return (pre > 2) ? $clog2(pre) : 1;
  endfunction

endpackage

// File: rtl/en_gen_ch.sv
// One divider channel: counts base ticks, emits a 1-clk enable at wrap and a blink mask.
// EN_GEN_DUTY_EN selects a programmable mask length instead of the default 50% mask.
module en_gen_ch #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  input  logic [DIV_W-1:0] div,
`ifdef EN_GEN_DUTY_EN
  input  logic [DIV_W-1:0] duty,
`endif
  output logic             en,
  output logic             mask
);

  logic [DIV_W-1:0] ch_cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_inc;
  logic             at_wrap;
  logic             mask_wrap;
  logic             mask_run;

  assign cnt_inc = ch_cnt + DIV_W'(1);
  assign at_wrap = (ch_cnt == div_q - DIV_W'(1));

  // mask_wrap uses the incoming period because a new div takes effect at the very wrap that loads it.
`ifdef EN_GEN_DUTY_EN
  logic [DIV_W-1:0] duty_q;
  assign mask_wrap = (div != '0) && (duty != '0);
  assign mask_run  = (cnt_inc < duty_q);
`else
  assign mask_wrap = ((div >> 1) != '0);
  assign mask_run  = (cnt_inc < (div_q >> 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ch_cnt <= '0;
      div_q  <= div;
`ifdef EN_GEN_DUTY_EN
      duty_q <= duty;
`endif
      en     <= 1'b0;
      mask   <= 1'b0;
    end else if (tick) begin
      if (div_q == '0) begin
        // Channel off: keep polling div on every tick until it becomes nonzero.
        ch_cnt <= '0;
        div_q  <= div;
`ifdef EN_GEN_DUTY_EN
        duty_q <= duty;
`endif
        en     <= 1'b0;
        mask   <= 1'b0;
      end else if (at_wrap) begin
        ch_cnt <= '0;
        div_q  <= div;
`ifdef EN_GEN_DUTY_EN
        duty_q <= duty;
`endif
        en     <= 1'b1;
        mask   <= mask_wrap;
      end else begin
        ch_cnt <= cnt_inc;
        en     <= 1'b0;
        mask   <= mask_run;
      end
    end else begin
      en <= 1'b0;
    end
  end

endmodule

// File: rtl/en_gen_multi.sv
// Multi-channel enable/blink generator: shared prescaler plus NUM_CH divider channels.
// Define EN_GEN_DUTY_EN to add the duty port and programmable mask length.
module en_gen_multi
  import en_gen_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    restart,
  input  logic [NUM_CH*DIV_W-1:0] div,
`ifdef EN_GEN_DUTY_EN
  input  logic [NUM_CH*DIV_W-1:0] duty,
`endif
  output logic                    tick_out,
  output logic [NUM_CH-1:0]       en_out,
  output logic [NUM_CH-1:0]       mask_out
);

  localparam int               PRE      = pre_val(CLK_HZ, TICK_HZ);
  localparam int               PRE_W    = pre_width(PRE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             wrap;

  // Channels advance on the same edge as the prescaler wrap so en_out lines up with tick_out.
  assign wrap = run && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      pre_cnt  <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= wrap;
      if (run) begin
        pre_cnt <= wrap ? '0 : pre_cnt + PRE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    en_gen_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(restart),
      .tick (wrap),
      .div  (div[i*DIV_W +: DIV_W]),
`ifdef EN_GEN_DUTY_EN
      .duty (duty[i*DIV_W +: DIV_W]),
`endif
      .en   (en_out[i]),
      .mask (mask_out[i])
    );
  end

endmodule
